// File: rtl/sha1_multi_guesser_if.sv
// Host-side bundle of the multi-lane nonce guesser: run control, search
// parameters and result reporting.
interface sha1_multi_guesser_if #(
  parameter int NONCE_SIZE = 32,
  parameter int COUNT_W    = 40
);
  logic                  start;
  logic                  abort;
  logic [159:0]          context_in;
  logic [511:0]          block_in;
  logic [159:0]          target;
  logic [159:0]          target_mask;
  logic [NONCE_SIZE-1:0] nonce_first;
  logic [NONCE_SIZE-1:0] nonce_last;
  logic                  busy;
  logic                  done;
  logic                  found;
  logic                  aborted;
  logic [NONCE_SIZE-1:0] match_nonce;
  logic [159:0]          match_context;
  logic [COUNT_W-1:0]    hash_count;

  modport master (
    output start, abort, context_in, block_in, target, target_mask, nonce_first, nonce_last,
    input  busy, done, found, aborted, match_nonce, match_context, hash_count
  );

  modport slave (
    input  start, abort, context_in, block_in, target, target_mask, nonce_first, nonce_last,
    output busy, done, found, aborted, match_nonce, match_context, hash_count
  );
endinterface

// File: rtl/sha1_multi_guesser.sv
// Multi-lane SHA-1 nonce search: LANES iterative sha1_block cores hash
// consecutive nonces in lockstep and the first match in nonce order is kept.
module sha1_multi_guesser #(
  parameter int NONCE_SIZE    = 32,
  parameter int NONCE_START   = 503,
  parameter int LANES         = 4,
  parameter int STOP_ON_MATCH = 1,
  parameter int COUNT_W       = 40
) (
  input  logic                clk,
  input  logic                rst,
  sha1_multi_guesser_if.slave bus
);
  localparam int SUM_W = NONCE_SIZE + 6;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_EVAL, S_DONE} state_t;

  state_t                r_state, w_state_next;
  logic [159:0]          r_ctx, r_target, r_mask, r_match_ctx;
  logic [511:0]          r_block;
  logic [NONCE_SIZE-1:0] r_base, r_last, r_match_nonce;
  logic [COUNT_W-1:0]    r_count;
  logic                  r_busy, r_done, r_found, r_aborted;

  logic                  w_accept, w_lane_start, w_any_hit, w_last_batch, w_exit;
  logic [LANES-1:0]      w_lane_done, w_valid, w_hit;
  logic [159:0]          w_lane_ctx [LANES];
  logic [NONCE_SIZE-1:0] w_lane_nonce [LANES];
  logic [NONCE_SIZE-1:0] w_sel_nonce;
  logic [159:0]          w_sel_ctx;
  logic [COUNT_W-1:0]    w_n_valid, w_count_next;
  logic [COUNT_W:0]      w_count_sum;
  logic [SUM_W-1:0]      w_end_sum;

  // Sums are kept wider than the nonce so running past all-ones invalidates a lane.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [SUM_W-1:0] w_sum;
    logic [511:0]     w_blk;

    assign w_sum           = SUM_W'(r_base) + SUM_W'(g);
    assign w_valid[g]      = (w_sum <= SUM_W'(r_last));
    assign w_lane_nonce[g] = w_sum[NONCE_SIZE-1:0];

    // Lane block: captured template with this lane's nonce spliced in.
    always_comb begin
      w_blk = r_block;
      w_blk[NONCE_START -: NONCE_SIZE] = w_sum[NONCE_SIZE-1:0];
    end

    sha1_block u_core (
      .clk       (clk),
      .i_start   (w_lane_start),
      .i_context (r_ctx),
      .i_block   (w_blk),
      .o_done    (w_lane_done[g]),
      .o_context (w_lane_ctx[g])
    );

    assign w_hit[g] = w_valid[g] & ((w_lane_ctx[g] & r_mask) == r_target);
  end

  // Lowest matching lane wins; also counts the valid lanes of the batch.
  always_comb begin
    w_sel_nonce = '0;
    w_sel_ctx   = '0;
    w_n_valid   = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      w_sel_nonce = w_hit[i] ? w_lane_nonce[i] : w_sel_nonce;
      w_sel_ctx   = w_hit[i] ? w_lane_ctx[i]   : w_sel_ctx;
      w_n_valid   = w_n_valid + COUNT_W'(w_valid[i]);
    end
  end

  assign w_any_hit    = |w_hit;
  assign w_count_sum  = {1'b0, r_count} + (COUNT_W + 1)'(w_n_valid);
  assign w_count_next = w_count_sum[COUNT_W] ? {COUNT_W{1'b1}} : w_count_sum[COUNT_W-1:0];
  assign w_end_sum    = SUM_W'(r_base) + SUM_W'(LANES);
  assign w_last_batch = ((w_end_sum - SUM_W'(1)) >= SUM_W'(r_last)) ||
                        (w_end_sum > SUM_W'({NONCE_SIZE{1'b1}}));
  assign w_exit       = bus.abort || ((STOP_ON_MATCH != 0) && w_any_hit) || w_last_batch;

  // Next-state and lane launch decode.
  always_comb begin
    w_state_next = r_state;
    w_lane_start = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = S_LAUNCH;
        end else begin
          w_state_next = r_state;
        end
      end
      S_LAUNCH: begin
        w_lane_start = 1'b1;
        w_state_next = S_WAIT;
      end
      // Lanes run in lockstep, so the AND of all done flags equals lane 0 done.
      S_WAIT: begin
        if (&w_lane_done) begin
          w_state_next = S_EVAL;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_EVAL:  w_state_next = w_exit ? S_DONE : S_LAUNCH;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, captured run parameters and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ctx         <= '0;
      r_target      <= '0;
      r_mask        <= '0;
      r_block       <= '0;
      r_base        <= '0;
      r_last        <= '0;
      r_count       <= '0;
      r_match_nonce <= '0;
      r_match_ctx   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_found       <= 1'b0;
      r_aborted     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_ctx     <= bus.context_in;
        r_block   <= bus.block_in;
        r_target  <= bus.target;
        r_mask    <= bus.target_mask;
        r_base    <= bus.nonce_first;
        r_last    <= bus.nonce_last;
        r_count   <= '0;
        r_busy    <= 1'b1;
        r_done    <= 1'b0;
        r_found   <= 1'b0;
        r_aborted <= 1'b0;
      end else if (r_state == S_EVAL) begin
        r_count <= w_count_next;
        if (!r_found && w_any_hit) begin
          r_found       <= 1'b1;
          r_match_nonce <= w_sel_nonce;
          r_match_ctx   <= w_sel_ctx;
        end
        if (w_exit) begin
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_aborted <= bus.abort;
        end else begin
          r_base <= r_base + NONCE_SIZE'(LANES);
        end
      end
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.found         = r_found;
  assign bus.aborted       = r_aborted;
  assign bus.match_nonce   = r_match_nonce;
  assign bus.match_context = r_match_ctx;
  assign bus.hash_count    = r_count;
endmodule

// One-round-per-cycle SHA-1 compression: o_done pulses 80 cycles after the
// cycle i_start is sampled, with o_context = i_context + compress(i_block).
module sha1_block (
  input  logic         clk,
  input  logic         i_start,
  input  logic [159:0] i_context,
  input  logic [511:0] i_block,
  output logic         o_done,
  output logic [159:0] o_context
);
  logic [31:0]  r_a, r_b, r_c, r_d, r_e;
  logic [159:0] r_h;
  logic [511:0] r_w;
  logic [6:0]   r_round;
  logic         r_run;
  logic [31:0]  w_f, w_k, w_temp, w_x, w_b30;

  // Round function and constant for the current 20-round group.
  always_comb begin
    if (r_round < 7'd20) begin
      w_f = (r_b & r_c) | (~r_b & r_d);
      w_k = 32'h5A827999;
    end else if (r_round < 7'd40) begin
      w_f = r_b ^ r_c ^ r_d;
      w_k = 32'h6ED9EBA1;
    end else if (r_round < 7'd60) begin
      w_f = (r_b & r_c) | (r_b & r_d) | (r_c & r_d);
      w_k = 32'h8F1BBCDC;
    end else begin
      w_f = r_b ^ r_c ^ r_d;
      w_k = 32'hCA62C1D6;
    end
  end

  // r_w is a 16-word window with W[t] at the top: W[t+16] = rotl1(W[t+13]^W[t+8]^W[t+2]^W[t]).
  assign w_x    = r_w[95:64] ^ r_w[255:224] ^ r_w[447:416] ^ r_w[511:480];
  assign w_temp = {r_a[26:0], r_a[31:27]} + w_f + r_e + w_k + r_w[511:480];
  assign w_b30  = {r_b[1:0], r_b[31:2]};

  // Round datapath; the core has no reset and only acts on i_start.
  always_ff @(posedge clk) begin
    o_done <= 1'b0;
    if (i_start) begin
      r_h     <= i_context;
      {r_a, r_b, r_c, r_d, r_e} <= i_context;
      r_w     <= i_block;
      r_round <= 7'd0;
      r_run   <= 1'b1;
    end else if (r_run) begin
      r_a     <= w_temp;
      r_b     <= r_a;
      r_c     <= w_b30;
      r_d     <= r_c;
      r_e     <= r_d;
      r_w     <= {r_w[479:0], w_x[30:0], w_x[31]};
      r_round <= r_round + 7'd1;
      if (r_round == 7'd79) begin
        r_run     <= 1'b0;
        o_done    <= 1'b1;
        o_context <= {r_h[159:128] + w_temp, r_h[127:96] + r_a, r_h[95:64] + w_b30,
                      r_h[63:32] + r_c, r_h[31:0] + r_d};
      end
    end
  end
endmodule

// File: tb/tb_sha1_multi_guesser.sv
// Directed bench for sha1_multi_guesser: three instances cover stop-on-match,
// full-range scan and an 8-bit nonce near the top of its range.
module tb_sha1_multi_guesser;
  localparam logic [159:0] H0  = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  // Padded single-block message "abc" and its published SHA-1 digest.
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [159:0] ABC_HASH = 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
  localparam logic [159:0] ONES = {160{1'b1}};
  localparam int BATCH = 83;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc;

  always #5 clk = ~clk;

  sha1_multi_guesser_if #(.NONCE_SIZE(32), .COUNT_W(40)) if0 ();
  sha1_multi_guesser_if #(.NONCE_SIZE(32), .COUNT_W(40)) if1 ();
  sha1_multi_guesser_if #(.NONCE_SIZE(8),  .COUNT_W(40)) if2 ();

  sha1_multi_guesser #(.NONCE_SIZE(32), .NONCE_START(503), .LANES(4), .STOP_ON_MATCH(1), .COUNT_W(40))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  sha1_multi_guesser #(.NONCE_SIZE(32), .NONCE_START(503), .LANES(4), .STOP_ON_MATCH(0), .COUNT_W(40))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  sha1_multi_guesser #(.NONCE_SIZE(8), .NONCE_START(503), .LANES(4), .STOP_ON_MATCH(1), .COUNT_W(40))
    u2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic get_done(input int u);
    case (u)
      0:       return if0.done;
      1:       return if1.done;
      default: return if2.done;
    endcase
  endfunction

  task automatic start_run(input int u, input logic [159:0] tgt, input logic [159:0] mask,
                           input logic [31:0] first, input logic [31:0] last);
    @(negedge clk);
    case (u)
      0: begin
        if0.context_in = H0; if0.block_in = ABC; if0.target = tgt; if0.target_mask = mask;
        if0.nonce_first = first; if0.nonce_last = last; if0.start = 1'b1;
      end
      1: begin
        if1.context_in = H0; if1.block_in = ABC; if1.target = tgt; if1.target_mask = mask;
        if1.nonce_first = first; if1.nonce_last = last; if1.start = 1'b1;
      end
      default: begin
        if2.context_in = H0; if2.block_in = ABC; if2.target = tgt; if2.target_mask = mask;
        if2.nonce_first = first[7:0]; if2.nonce_last = last[7:0]; if2.start = 1'b1;
      end
    endcase
    @(negedge clk);
    if0.start = 1'b0;
    if1.start = 1'b0;
    if2.start = 1'b0;
  endtask

  task automatic wait_done(input int u, input int c0, output int c);
    c = c0;
    while (!get_done(u) && c < 3000) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    {if0.start, if0.abort, if1.start, if1.abort, if2.start, if2.abort} = 6'b0;
    {if0.context_in, if0.block_in, if0.target, if0.target_mask, if0.nonce_first, if0.nonce_last} = '0;
    {if1.context_in, if1.block_in, if1.target, if1.target_mask, if1.nonce_first, if1.nonce_last} = '0;
    {if2.context_in, if2.block_in, if2.target, if2.target_mask, if2.nonce_first, if2.nonce_last} = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_busy",  if0.busy, 0);
    check_val("rst_done",  if0.done, 0);
    check_val("rst_found", if0.found, 0);
    check_val("rst_abort", if0.aborted, 0);
    check_val("rst_nonce", if0.match_nonce, 0);
    check_val("rst_ctx",   if0.match_context, 0);
    check_val("rst_count", if0.hash_count, 0);

    // Mask 0 matches everything: stop after the first batch on nonce 10.
    start_run(0, '0, '0, 32'd10, 32'd20);
    check_val("t1_busy", if0.busy, 1);
    wait_done(0, 0, cyc);
    check_val("t1_cycles", cyc, BATCH);
    check_val("t1_found",  if0.found, 1);
    check_val("t1_nonce",  if0.match_nonce, 10);
    check_val("t1_count",  if0.hash_count, 4);
    check_val("t1_busy_end", if0.busy, 0);

    // Full scan of 10..20: three batches, 21 invalid; a start mid-run is ignored.
    start_run(1, '0, '0, 32'd10, 32'd20);
    repeat (40) @(negedge clk);
    if1.nonce_first = 32'd0;
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    wait_done(1, 41, cyc);
    check_val("t2_cycles", cyc, 3 * BATCH);
    check_val("t2_count",  if1.hash_count, 11);
    check_val("t2_nonce",  if1.match_nonce, 10);
    check_val("t2_found",  if1.found, 1);

    // 8-bit nonce FC..FF: one batch, no wrap to 0 afterwards.
    start_run(2, '0, ONES, 32'hFC, 32'hFF);
    wait_done(2, 0, cyc);
    check_val("t3_cycles", cyc, BATCH);
    check_val("t3_found",  if2.found, 0);
    check_val("t3_count",  if2.hash_count, 4);
    repeat (100) @(negedge clk);
    check_val("t3_still_done", if2.done, 1);
    check_val("t3_idle_busy",  if2.busy, 0);
    check_val("t3_count_hold", if2.hash_count, 4);

    // Abort raised in the second WAIT: ends after the second EVAL.
    start_run(0, '0, ONES, 32'd0, 32'd1000);
    repeat (BATCH + 20) @(negedge clk);
    if0.abort = 1'b1;
    wait_done(0, BATCH + 20, cyc);
    if0.abort = 1'b0;
    check_val("t4_cycles",  cyc, 2 * BATCH);
    check_val("t4_aborted", if0.aborted, 1);
    check_val("t4_count",   if0.hash_count, 8);
    check_val("t4_found",   if0.found, 0);
    check_val("t4_nonce_hold", if0.match_nonce, 10);

    // Empty range 5..3: one batch, nothing valid.
    start_run(0, '0, '0, 32'd5, 32'd3);
    wait_done(0, 0, cyc);
    check_val("t5_cycles",  cyc, BATCH);
    check_val("t5_count",   if0.hash_count, 0);
    check_val("t5_found",   if0.found, 0);
    check_val("t5_done",    if0.done, 1);
    check_val("t5_aborted", if0.aborted, 0);

    // Nonce 0x62638000 turns the template into the "abc" block; it is 8th in range.
    start_run(0, ABC_HASH, ONES, 32'h62637FF9, 32'h62638008);
    wait_done(0, 0, cyc);
    check_val("t6_cycles", cyc, 2 * BATCH);
    check_val("t6_found",  if0.found, 1);
    check_val("t6_nonce",  if0.match_nonce, 32'h62638000);
    check_val("t6_ctx",    if0.match_context, ABC_HASH);
    check_val("t6_count",  if0.hash_count, 8);

    // Reset in the middle of a run clears everything and parks in IDLE.
    start_run(0, '0, ONES, 32'd0, 32'd1000);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("t7_busy",  if0.busy, 0);
    check_val("t7_done",  if0.done, 0);
    check_val("t7_found", if0.found, 0);
    check_val("t7_abort", if0.aborted, 0);
    check_val("t7_nonce", if0.match_nonce, 0);
    check_val("t7_ctx",   if0.match_context, 0);
    check_val("t7_count", if0.hash_count, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check_val("t7_idle_busy", if0.busy, 0);
    check_val("t7_idle_done", if0.done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sha1_multi_guesser.md
Name: sha1_multi_guesser

Overview:
Parametrised successor to the single-lane nonce guesser. Runs LANES sha1_block instances in lockstep, so each batch hashes LANES consecutive nonces. Scans a programmable inclusive nonce range [nonce_first, nonce_last], compares each result against target/target_mask, and either stops on the first match or scans the whole range. Sits between the host/control register block and the sha1_block cores.

Parameters:
NONCE_SIZE, 32, nonce width in bits (1..32)
NONCE_START, 503, block bit index of the nonce MSB; nonce occupies [NONCE_START:NONCE_START-NONCE_SIZE+1]
LANES, 4, parallel sha1_block instances; power of two, 1..16
STOP_ON_MATCH, 1, 1 = finish at the first matching batch; 0 = scan the full range and report the first match
COUNT_W, 40, width of the hash counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; accepted only in IDLE or DONE
abort  in  1  level; forces DONE at the next batch boundary
context_in  in  160  chaining value, sampled at accepted start
block_in  in  512  message block template, sampled at accepted start
target  in  160  compare value, sampled at start
target_mask  in  160  compare mask, sampled at start
nonce_first  in  NONCE_SIZE  first nonce, sampled at start
nonce_last  in  NONCE_SIZE  last nonce inclusive, sampled at start
busy  out  1  high from the cycle after an accepted start until DONE
done  out  1  level; high in DONE until the next accepted start
found  out  1  a match has been latched for the current run
aborted  out  1  the run ended because of abort
match_nonce  out  NONCE_SIZE  nonce of the latched match
match_context  out  160  sha1 output of the latched match
hash_count  out  COUNT_W  number of valid nonces hashed in this run

Behaviour:
- Reset values: busy=0, done=0, found=0, aborted=0, match_nonce=0, match_context=0, hash_count=0, FSM=IDLE. sha1_block has no reset; any done pulse arriving outside WAIT is ignored.
- States: IDLE -> LAUNCH on start. LAUNCH pulses start to every lane for exactly one cycle, then goes to WAIT. WAIT holds until lane 0 reports done; all lanes finish in the same cycle, so lane 0 done is authoritative. WAIT -> EVAL for one cycle. EVAL -> DONE or LAUNCH. DONE -> LAUNCH on start.
- Lane i hashes block_in with the nonce field replaced by base+i. base starts at nonce_first.
- Lane i is valid iff base+i <= nonce_last. Compute the sum in NONCE_SIZE+1 bits so that wrap past all-ones makes a lane invalid rather than wrapping to 0.
- Invalid lanes still hash but are never matched or counted.
- Lane match = valid & ((context_out & target_mask) == target).
- If several lanes match, the lowest index wins.
- The match is latched only while found=0, so the first match in nonce order is kept.
- EVAL actions:
  - Add the number of valid lanes to hash_count; the counter saturates at all-ones.
  - Latch any match as above.
  - Go to DONE if any of these holds: abort, (STOP_ON_MATCH and a match), base+LANES-1 >= nonce_last, or base+LANES overflows NONCE_SIZE.
  - Otherwise base += LANES and return to LAUNCH.
- Batch period = sha1 latency + 3 cycles.
- If nonce_first > nonce_last: exactly one batch runs, all lanes are invalid, hash_count=0, found=0, then DONE.
- abort is checked only in EVAL; an in-flight batch always completes and is evaluated. Set aborted=1 only if abort caused the exit.
- start while busy is ignored.
- Accepted start clears found, aborted, hash_count and done, and captures all inputs.
- match_nonce and match_context hold their values from the previous run until overwritten by a new match.
- rst mid-run returns the FSM to IDLE immediately with all outputs at reset values.

Test Plan:
- target_mask=0, target=0, range 10..20, LANES=4, STOP_ON_MATCH=1 -> done after 1 batch, found=1, match_nonce=10, hash_count=4.
- Same with STOP_ON_MATCH=0 -> 3 batches; the last batch has lanes 18..20 valid and 21 invalid; hash_count=11, match_nonce=10.
- NONCE_SIZE=8, range 0xFC..0xFF, target_mask=all-ones, target=0 -> one batch, found=0, hash_count=4, done with no wrap to 0.
- Range 5..3 -> one batch, hash_count=0, found=0, done=1.
- abort asserted in the second WAIT of range 0..1000 -> done after the second EVAL, aborted=1, hash_count=8.
- Target set to the known SHA-1 of the template with nonce 7, range 0..15 -> found=1, match_nonce=7, match_context=target, hash_count=8. Then assert rst mid-run -> all outputs are 0 and the FSM is in IDLE.
